pwm_audio_mod: RTL and testbench
================================

# pwm_audio_mod

Downstream PWM modulator for the audio path. Consumes 8-bit unsigned audio samples from the sample register stage through a valid/ready handshake. Buffers one pending sample and reloads the active sample at a fixed sample rate. Drives a single-bit PWM output for the external RC filter and amplifier, and flags underflow when no sample is pending at a reload instant.

## Interface
Parameters:
- SAMPLE_DIV, 1024: clocks per sample period; must be >= 256 (elaboration error otherwise).
- DW, 8: sample width; fixed at 8, and PWM period is 2^DW clocks.

Ports:
- i_clk, input, 1: single clock.
- i_reset_n, input, 1: asynchronous, active-low reset.
- i_enable, input, 1: run request.
- i_valid, input, 1: i_data holds a sample.
- o_ready, output, 1: block accepts a sample this cycle.
- i_data, input, DW: unsigned sample; 0x80 is midscale.
- i_clr_uflow, input, 1: clears o_underflow.
- o_pwm, output, 1: PWM output, registered.
- o_shutdown_n, output, 1: amplifier enable; high only in RUN.
- o_tick, output, 1: one-cycle pulse on each sample reload, registered.
- o_underflow, output, 1: sticky underflow flag.

## Operation
- Storage:
  - buf_data and buf_full form the one-entry pending buffer.
  - active holds the sample currently being modulated.
- Counters:
  - timer counts down from SAMPLE_DIV-1 to 0.
  - pwm_cnt is DW bits and increments by 1, wrapping at 255.
- A handshake completes when i_valid and o_ready are both high; the sample is written to buf_data and buf_full is set.
- o_ready = !buf_full || tick. This is combinational from registers and does not depend on i_valid.
- tick = (state == RUN) && (timer == 0).
- FSM states:
  - IDLE:
    - o_pwm = 0 and o_shutdown_n = 0; timer and pwm_cnt are held at 0.
    - The handshake stays active, so the buffer can be primed.
    - Go to RUN when i_enable && buf_full.
  - RUN:
    - timer and pwm_cnt count as described above.
    - Go to IDLE immediately when !i_enable. On that transition timer and pwm_cnt are cleared; buf_data, buf_full and active are kept.
- Entry into RUN forces timer = 0, so the first RUN cycle is a tick.
- On a tick:
  - timer <= SAMPLE_DIV-1 and pwm_cnt <= 0, so each sample period starts a fresh PWM period.
  - If buf_full: active <= buf_data and buf_full is cleared, unless a handshake happens in the same cycle. In that case buf_data takes the new sample and buf_full stays 1.
  - If !buf_full: active holds its value and o_underflow <= 1.
- PWM output:
  - o_pwm <= (state == RUN) && (pwm_cnt < active).
  - Duty is active/256: 0x00 gives constant low; 0xFF gives 255 high clocks per 256.
  - The PWM period is 256 clocks. If SAMPLE_DIV is not a multiple of 256, the last period in each sample is truncated.
- o_underflow clearing:
  - i_clr_uflow clears the flag.
  - If clear and an underflow tick happen in the same cycle, the set wins.
- The DW width is enforced everywhere; no sign conversion is applied (unsigned in, unsigned compare).

## Timing
- Reset values: state = IDLE, and all of the following are 0: timer, pwm_cnt, active, buf_data, buf_full, o_pwm, o_tick, o_underflow, o_shutdown_n.
- Reset mid-operation aborts immediately (asynchronous). o_pwm and o_shutdown_n go low without waiting for a clock.
- o_tick is asserted in the cycle after the tick cycle, aligned with the first cycle in which the new active is valid.
- o_pwm is registered, one cycle after the compare: o_pwm[k+1] = pwm_cnt[k] < active[k].
- Latency from a handshake at cycle t, with RUN and the buffer previously empty:
  - The sample reaches active at the next tick edge.
  - Its first PWM level appears on o_pwm one edge later.
- Throughput: one sample per SAMPLE_DIV clocks. A full buffer back-pressures the source by holding o_ready = 0 until the next tick.
- o_shutdown_n is registered and rises one cycle after entry to RUN.

## Structure
- Package pwm_audio_pkg:
  - state_t enum {IDLE, RUN}.
  - localparam PWM_BITS = 8.
  - Function sample_div_ok() for the parameter check.
- Sub-module pwm_audio_timer:
  - Contains the timer down-counter and pwm_cnt.
  - Inputs: run, restart.
  - Outputs: tick, pwm_cnt.
- The top level holds the FSM, the buffer, active and the output registers.

## Test plan
- Prime and run: write 0x40 in IDLE, then raise i_enable.
  - o_shutdown_n rises; o_tick pulses one cycle after entry.
  - o_pwm is high for exactly 64 of each 256 clocks.
  - o_underflow stays 0 while the source writes one sample per period.
- Extremes: samples 0x00 then 0xFF.
  - o_pwm is constantly 0 for sample 0x00.
  - For sample 0xFF, o_pwm is high for 255 clocks then low for 1, in each period.
- Back-pressure: hold i_valid = 1 continuously.
  - o_ready is low from the accept until each tick.
  - Exactly one handshake per SAMPLE_DIV clocks; no sample is lost or duplicated (check the sequence 0x01, 0x02, 0x03...).
- Simultaneous tick and write: present 0x90 in the tick cycle with the buffer holding 0x10.
  - active becomes 0x10.
  - buf_data becomes 0x90 and buf_full stays 1.
- Underflow: stop writing.
  - o_underflow is set at the first empty tick, and active holds its last value.
  - Pulsing i_clr_uflow in a non-tick cycle clears the flag; if clear and an underflow tick coincide, the flag stays 1.
- Disable and reset mid-run:
  - Dropping i_enable gives o_pwm = 0 and o_shutdown_n = 0 on the next edge, with the buffered sample kept.
  - Asserting i_reset_n = 0 mid-period forces all outputs low asynchronously, and buf_full reads 0 after reset.

Source files
------------

// File: rtl/pwm_audio_pkg.sv
// Shared types and constants for the PWM audio modulator.
// The state encodings are also exposed as plain 1-bit constants for legacy code.
package pwm_audio_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef enum logic [0:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN
  } state_t;

  localparam int PWM_BITS = 8;

  // A sample period must hold at least one full PWM period.
  function automatic bit sample_div_ok(input int div);
    return div >= (1 << PWM_BITS);
  endfunction

endpackage

// File: rtl/pwm_audio_if.sv
// Valid/ready sample channel from the sample register stage.
// The modulator is the slave side of this channel.
interface pwm_audio_if #(
  parameter int DW = 8
);
  logic          i_valid;
  logic          o_ready;
  logic [DW-1:0] i_data;

  modport master (output i_valid, output i_data, input o_ready);
  modport slave  (input i_valid, input i_data, output o_ready);
endinterface

// File: rtl/pwm_audio_timer.sv
// Sample-period down-counter plus free-running PWM phase counter.
// Both counters restart together on every tick.
module pwm_audio_timer #(
  parameter int SAMPLE_DIV = 1024,
  parameter int DW         = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic          restart,
  output logic          tick,
  output logic [DW-1:0] pwm_cnt
);

  localparam int TW = $clog2(SAMPLE_DIV);

  logic [TW-1:0] timer_reg;
  logic [DW-1:0] pwm_cnt_reg;

  assign tick    = run && (timer_reg == '0);
  assign pwm_cnt = pwm_cnt_reg;

  // Holding the timer at 0 while stopped makes the first running cycle a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_reg   <= '0;
      pwm_cnt_reg <= '0;
    end else if (!run || restart) begin
      timer_reg   <= '0;
      pwm_cnt_reg <= '0;
    end else if (tick) begin
      timer_reg   <= TW'(SAMPLE_DIV - 1);
      pwm_cnt_reg <= '0;
    end else begin
      timer_reg   <= timer_reg - 1'b1;
      pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_audio_mod.sv
// PWM audio modulator: one-entry sample buffer, active sample reloaded each
// sample period, registered PWM / tick / amplifier-enable / underflow outputs.
module pwm_audio_mod
  import pwm_audio_pkg::*;
#(
  parameter int SAMPLE_DIV = 1024,
  parameter int DW         = 8
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_enable,
  pwm_audio_if.slave  sif,
  input  logic        i_clr_uflow,
  output logic        o_pwm,
  output logic        o_shutdown_n,
  output logic        o_tick,
  output logic        o_underflow
);

  if (!sample_div_ok(SAMPLE_DIV)) begin : g_bad_div
    $error("pwm_audio_mod: SAMPLE_DIV must be >= 256");
  end
  if (DW != PWM_BITS) begin : g_bad_dw
    $error("pwm_audio_mod: DW must be 8");
  end

  state_t        state_reg;
  state_t        state_next;
  logic [DW-1:0] buf_data_reg;
  logic          buf_full_reg;
  logic [DW-1:0] active_reg;
  logic [DW-1:0] pwm_cnt;
  logic          tick;
  logic          hs;
  logic          in_run;
  logic          drop;
  logic          run_keep;

  assign in_run      = (state_reg == RUN);
  assign drop        = in_run && !i_enable;
  assign run_keep    = in_run && i_enable;
  assign sif.o_ready = !buf_full_reg || tick;
  assign hs          = sif.i_valid && sif.o_ready;

  pwm_audio_timer #(
    .SAMPLE_DIV (SAMPLE_DIV),
    .DW         (DW)
  ) u_timer (
    .clk     (i_clk),
    .rst_n   (i_reset_n),
    .run     (in_run),
    .restart (drop),
    .tick    (tick),
    .pwm_cnt (pwm_cnt)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (i_enable && buf_full_reg) state_next = RUN;
      RUN:     if (!i_enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg    <= IDLE;
      buf_data_reg <= '0;
      buf_full_reg <= 1'b0;
      active_reg   <= '0;
      o_pwm        <= 1'b0;
      o_shutdown_n <= 1'b0;
      o_tick       <= 1'b0;
      o_underflow  <= 1'b0;
    end else begin
      state_reg <= state_next;

      // A write landing on a reload refills the entry just drained.
      if (hs) begin
        buf_data_reg <= sif.i_data;
        buf_full_reg <= 1'b1;
      end else if (tick && buf_full_reg) begin
        buf_full_reg <= 1'b0;
      end

      if (tick && buf_full_reg) begin
        active_reg <= buf_data_reg;
      end

      if (tick && !buf_full_reg) begin
        o_underflow <= 1'b1;
      end else if (i_clr_uflow) begin
        o_underflow <= 1'b0;
      end

      // Outputs drop on the same edge that leaves RUN.
      o_tick       <= tick;
      o_pwm        <= run_keep && (pwm_cnt < active_reg);
      o_shutdown_n <= run_keep;
    end
  end

endmodule

// File: tb/tb_pwm_audio_mod.sv
// Directed bench for pwm_audio_mod with a 256-clock sample period; each check
// is an immediate assertion comparing an observed value with a hand-derived one.
module tb_pwm_audio_mod;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  logic clr;
  logic o_pwm, o_shutdown_n, o_tick, o_underflow;

  int n_assert = 0;
  int n_fail   = 0;

  pwm_audio_if #(.DW(8)) sif ();

  pwm_audio_mod #(
    .SAMPLE_DIV (256),
    .DW         (8)
  ) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_enable     (enable),
    .sif          (sif),
    .i_clr_uflow  (clr),
    .o_pwm        (o_pwm),
    .o_shutdown_n (o_shutdown_n),
    .o_tick       (o_tick),
    .o_underflow  (o_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One sample period starting at the negedge after a tick edge; optional write at i=10.
  task automatic run_period(input bit wr, input logic [7:0] wd,
                            output int highs, output int ticks, output logic last);
    highs = 0;
    ticks = 0;
    last  = 1'b0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      highs += int'(o_pwm);
      ticks += int'(o_tick);
      if (i == 255) last = o_pwm;
      if (wr && i == 10) begin
        sif.i_valid = 1'b1;
        sif.i_data  = wd;
      end
      if (i == 11) sif.i_valid = 1'b0;
    end
  endtask

  initial begin
    int         highs, ticks, hs_cnt, rdy_hi;
    logic       last, prev_ready;
    logic [7:0] seq, exp_act;

    rst_n = 1'b0; enable = 1'b0; clr = 1'b0;
    sif.i_valid = 1'b0; sif.i_data = 8'h00;
    cycles(2);
    chk("rst_pwm", o_pwm, 0);
    chk("rst_shdn", o_shutdown_n, 0);
    chk("rst_tick", o_tick, 0);
    chk("rst_uflow", o_underflow, 0);
    chk("rst_ready", sif.o_ready, 1);
    chk("rst_buf_full", dut.buf_full_reg, 0);
    rst_n = 1'b1;
    cycles(1);

    // Prime the buffer in IDLE, then enable
    sif.i_valid = 1'b1; sif.i_data = 8'h40;
    cycles(1);
    sif.i_valid = 1'b0;
    chk("prime_full", dut.buf_full_reg, 1);
    chk("prime_data", dut.buf_data_reg, 8'h40);
    chk("prime_ready", sif.o_ready, 0);
    chk("prime_shdn", o_shutdown_n, 0);
    enable = 1'b1;
    cycles(1);
    chk("entry_shdn", o_shutdown_n, 0);
    chk("entry_tick", o_tick, 0);
    chk("entry_ready", sif.o_ready, 1);
    cycles(1);
    chk("first_tick", o_tick, 1);
    chk("first_shdn", o_shutdown_n, 1);
    chk("first_active", dut.active_reg, 8'h40);
    chk("first_buf_empty", dut.buf_full_reg, 0);

    run_period(1'b1, 8'h40, highs, ticks, last);
    chk("p1_highs", highs, 64);
    chk("p1_ticks", ticks, 1);
    chk("p1_uflow", o_underflow, 0);
    run_period(1'b1, 8'h00, highs, ticks, last);
    chk("p2_highs", highs, 64);
    chk("p2_active", dut.active_reg, 8'h00);
    run_period(1'b1, 8'hFF, highs, ticks, last);
    chk("p3_highs_zero", highs, 0);
    chk("p3_active", dut.active_reg, 8'hFF);

    // Back-pressure: valid held high, sequence 1,2,3,...
    chk("bp_ready_start", sif.o_ready, 1);
    seq = 8'h01; exp_act = 8'h01;
    sif.i_valid = 1'b1; sif.i_data = seq;
    prev_ready = sif.o_ready;
    hs_cnt = 0; rdy_hi = 0; highs = 0; last = 1'b0;
    for (int c = 0; c < 768; c++) begin
      @(negedge clk);
      if (prev_ready) begin
        hs_cnt++;
        seq = seq + 8'h01;
        sif.i_data = seq;
      end
      if (c < 256) highs += int'(o_pwm);
      if (c == 255) last = o_pwm;
      if (o_tick) begin
        chk("bp_active", dut.active_reg, exp_act);
        exp_act = exp_act + 8'h01;
      end
      if (sif.o_ready) rdy_hi++;
      prev_ready = sif.o_ready;
    end
    sif.i_valid = 1'b0;
    chk("ff_highs", highs, 255);
    chk("ff_last_low", last, 0);
    chk("bp_handshakes", hs_cnt, 4);
    chk("bp_ready_high_cycles", rdy_hi, 3);
    chk("bp_ticks", exp_act, 8'h04);
    chk("bp_buf_data", dut.buf_data_reg, 8'h04);
    chk("bp_uflow", o_underflow, 0);

    // Write landing in the tick cycle
    cycles(256);
    chk("sim_pre_active", dut.active_reg, 8'h04);
    chk("sim_pre_empty", dut.buf_full_reg, 0);
    sif.i_valid = 1'b1; sif.i_data = 8'h10;
    cycles(1);
    sif.i_valid = 1'b0;
    chk("sim_buf_10", dut.buf_data_reg, 8'h10);
    cycles(254);
    chk("sim_ready_tick", sif.o_ready, 1);
    sif.i_valid = 1'b1; sif.i_data = 8'h90;
    cycles(1);
    sif.i_valid = 1'b0;
    chk("sim_active", dut.active_reg, 8'h10);
    chk("sim_buf_data", dut.buf_data_reg, 8'h90);
    chk("sim_buf_full", dut.buf_full_reg, 1);

    // Underflow
    cycles(256);
    chk("uf_active_90", dut.active_reg, 8'h90);
    chk("uf_not_yet", o_underflow, 0);
    cycles(256);
    chk("uf_set", o_underflow, 1);
    chk("uf_active_held", dut.active_reg, 8'h90);
    clr = 1'b1;
    cycles(1);
    clr = 1'b0;
    chk("uf_cleared", o_underflow, 0);
    cycles(254);
    clr = 1'b1;
    cycles(1);
    clr = 1'b0;
    chk("uf_set_wins", o_underflow, 1);
    chk("uf_tick", o_tick, 1);

    // Disable mid-run keeps the buffered sample
    sif.i_valid = 1'b1; sif.i_data = 8'h55;
    cycles(1);
    sif.i_valid = 1'b0;
    chk("dis_pwm_before", o_pwm, 1);
    chk("dis_shdn_before", o_shutdown_n, 1);
    enable = 1'b0;
    cycles(1);
    chk("dis_pwm", o_pwm, 0);
    chk("dis_shdn", o_shutdown_n, 0);
    chk("dis_state", dut.state_reg, 0);
    chk("dis_buf_full", dut.buf_full_reg, 1);
    chk("dis_buf_data", dut.buf_data_reg, 8'h55);
    chk("dis_active", dut.active_reg, 8'h90);
    chk("dis_pwm_cnt", dut.u_timer.pwm_cnt_reg, 0);

    // Re-enable, then asynchronous reset mid-period
    enable = 1'b1;
    cycles(2);
    chk("re_tick", o_tick, 1);
    chk("re_active", dut.active_reg, 8'h55);
    cycles(3);
    chk("re_pwm", o_pwm, 1);
    chk("re_uflow_sticky", o_underflow, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pwm", o_pwm, 0);
    chk("arst_shdn", o_shutdown_n, 0);
    chk("arst_tick", o_tick, 0);
    chk("arst_uflow", o_underflow, 0);
    chk("arst_buf_full", dut.buf_full_reg, 0);
    chk("arst_active", dut.active_reg, 0);
    cycles(2);
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
